pipe_fetch_stage: RTL

Instruction-fetch front end for the pipelined CPU. It owns the program counter and runs a request/acknowledge handshake against instruction memory, so that memory may respond with zero or more wait states. It also holds a one-entry skid buffer, so a stall from the decode stage never breaks a memory transaction. It drives the IF/ID boundary (`instr_o`, `pc_o`, `pc_plus4_o`, `valid_o`) and accepts branch/jump redirects from later stages.

---
 rtl/pipe_fetch_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_fetch_stage.sv
// pipe_fetch_stage -- instruction-fetch front end of the pipelined CPU.
//
// Owns the fetch PC and runs a req/ack handshake with instruction memory.
// Memory may insert any number of wait states. A one-entry skid buffer
// catches a response that lands while decode is stalling, so an accepted
// memory transaction is never lost. Redirects from later stages flush the
// IF/ID slot and the skid buffer. If a request is still outstanding when a
// redirect arrives, that request is allowed to finish (DROP state) before
// fetching resumes at the target.
//
// Optional feature: define FETCH_PERF_EN to add the fetch_cnt_o/drop_cnt_o
// performance counters.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   stall_i               decode cannot accept (only meaningful when valid_o=1)
//   redirect_i/_pc_i      flush and refetch from target (bits [1:0] ignored)
//   imem_req_o/_addr_o    fetch request and byte address (held until ack)
//   imem_ack_i/_data_i    memory response, data valid with ack
//   instr_o, pc_o,
//   pc_plus4_o, valid_o   IF/ID boundary
//   pc_out_o              current fetch PC
//   fetch_cnt_o           instructions loaded into the slot   (FETCH_PERF_EN)
//   drop_cnt_o            responses discarded by a redirect   (FETCH_PERF_EN)
module pipe_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o,
`endif
  output logic [31:0] pc_out_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_pc4_q, slot_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        slot_free;
  logic        load_slot;
  logic        slot_from_skid;
  logic [31:0] tgt_in;
  logic [31:0] pc_inc;

  assign slot_free = !valid_q || !stall_i;
  assign tgt_in    = redirect_pc_i & 32'hFFFF_FFFC;
  assign pc_inc    = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    instr_d        = instr_q;
    slot_pc_d      = slot_pc_q;
    slot_pc4_d     = slot_pc4_q;
    // The held instruction is consumed whenever decode is not stalling.
    valid_d        = valid_q & stall_i;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    load_slot      = 1'b0;
    slot_from_skid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (redirect_i) pc_d = tgt_in;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            pc_d = tgt_in;
          end else begin
            // Address must stay put until ack; remember where to go next.
            tgt_d   = tgt_in;
            state_d = S_DROP;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_inc;
          if (slot_free) begin
            load_slot = 1'b1;
          end else begin
            skid_instr_d = imem_data_i;
            skid_pc_d    = pc_q;
            state_d      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = tgt_in;
          state_d = S_REQ;
        end else if (!stall_i) begin
          load_slot      = 1'b1;
          slot_from_skid = 1'b1;
          state_d        = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack_i) begin
          // A redirect arriving together with the ack supersedes tgt_q.
          pc_d    = redirect_i ? tgt_in : tgt_q;
          state_d = S_REQ;
        end else if (redirect_i) begin
          tgt_d = tgt_in;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_slot) begin
      valid_d = 1'b1;
      if (slot_from_skid) begin
        instr_d    = skid_instr_q;
        slot_pc_d  = skid_pc_q;
        slot_pc4_d = skid_pc_q + 32'd4;
      end else begin
        instr_d    = imem_data_i;
        slot_pc_d  = pc_q;
        slot_pc4_d = pc_inc;
      end
    end

    if (redirect_i) begin
      valid_d      = 1'b0;
      skid_instr_d = 32'h0;
      skid_pc_d    = 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      tgt_q        <= 32'h0;
      instr_q      <= 32'h0;
      slot_pc_q    <= 32'h0;
      slot_pc4_q   <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      instr_q      <= instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_pc4_q   <= slot_pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        drop_evt;

  // Any ack in DROP is a discarded response, as is an ack in REQ that
  // coincides with a redirect.
  assign drop_evt = imem_ack_i &&
                    ((state_q == S_DROP) || ((state_q == S_REQ) && redirect_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'h0;
      drop_cnt_q  <= 32'h0;
    end else begin
      if (load_slot) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop_evt)  drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

  assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = slot_pc_q;
  assign pc_plus4_o  = slot_pc4_q;
  assign valid_o     = valid_q;
  assign pc_out_o    = pc_q;

endmodule
